mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one port of the dual-port 1024x16 program/data block RAM between two requesters: requester 0 is instruction fetch, requester 1 is load/store.
- Grants one access per clock.
- Drives the RAM port's we/addr/din and returns the RAM dout to the requester that issued the read, with a valid strobe.
- Supports a short lock so a requester can perform an uninterrupted read-modify-write sequence.

Parameters:
- ADDR_W, 10, RAM word-address width.
- DATA_W, 16, RAM data width.
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, requester 0 wins.
- LOCK_MAX, 15, maximum consecutive locked cycles before the lock is forcibly released (4-bit counter).

Ports:
- clk  in  1  single system clock; the RAM samples on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r0_req  in  1  requester 0 access request.
- r0_we  in  1  requester 0 write enable (1 = write).
- r0_lock  in  1  requester 0 keep-grant request.
- r0_addr  in  ADDR_W  requester 0 word address.
- r0_wdata  in  DATA_W  requester 0 write data.
- r0_gnt  out  1  requester 0 access accepted this cycle.
- r0_rdata  out  DATA_W  requester 0 read data.
- r0_rvalid  out  1  requester 0 read data valid.
- r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rdata, r1_rvalid: same widths and meanings for requester 1.
- mem_we  out  1  RAM port write enable.
- mem_addr  out  ADDR_W  RAM port address.
- mem_din  out  DATA_W  RAM port write data.
- mem_dout  in  DATA_W  RAM port read data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - last_id = 1, so requester 0 wins the first contended round-robin cycle.
  - lock_valid = 0, lock_cnt = 0, read-pipeline valid = 0.
  - r*_rdata = 0, r*_rvalid = 0.
  - r*_gnt and mem_we are forced to 0 while rst_n is low.
- Request handshake:
  - The requester holds req/we/addr/wdata stable until it sees gnt.
  - gnt is combinational in the same cycle; the RAM access occurs on that rising edge.
  - A write is complete at gnt.
  - Back-to-back grants to the same requester are allowed every cycle.
- Arbitration (combinational, one winner per cycle):
  - When lock_valid is set, only lock_id is eligible.
  - Otherwise, with one request active, that requester wins.
  - With both active: PRIO_MODE=0 grants the requester that is not last_id; PRIO_MODE=1 grants requester 0.
  - last_id updates to the winner on every grant.
- RAM drive:
  - mem_addr/mem_din/mem_we are taken from the winner.
  - With no grant: mem_we=0, and mem_addr/mem_din = 0.
- Read return:
  - A granted read (we=0) pushes {valid, id} into a 1-stage pipe.
  - The next cycle, rvalid of that id is 1 for exactly one cycle, and rdata is loaded from mem_dout.
  - rdata holds its value until the next read return for that requester.
  - A read return and a new grant to either requester may coincide.
- Lock state machine: states UNLOCKED and LOCKED(id).
  - UNLOCKED -> LOCKED(id) on a grant with lock=1; lock_cnt = 0.
  - LOCKED: lock_cnt increments every cycle, saturating at LOCK_MAX.
  - LOCKED -> UNLOCKED on any of:
    - a granted access by the owner with lock=0; that access is still performed;
    - the owner dropping req;
    - lock_cnt reaching LOCK_MAX. The other requester becomes eligible on the following cycle, and the owner's lock input is ignored for one cycle, so it cannot immediately re-lock.
- Boundaries:
  - Address wrap is the RAM's concern; there is no range checking.
  - Write data is passed through unmodified.
  - Reset mid-read drops the pending rvalid.
  - Reset mid-lock clears the lock.

Optional Feature:
- MEM_ARB_OUTREG_EN: for use with the RAM's optional output register.
- Defined: read pipe is 2 stages, so rvalid/rdata arrive 2 cycles after gnt. Reads may still be issued every cycle, and ids stay in order.
- Undefined: 1-cycle read latency as above.

Decomposition:
- Shared package mem_arb_pkg:
  - requester id constants REQ_FETCH=0, REQ_LDST=1;
  - PRIO_RR/PRIO_FIXED encodings;
  - the read-pipe entry typedef {valid, id}.
- One natural sub-module, mem_arb_rdpipe: the parameterisable-depth {valid, id} return pipe plus rdata steering.
- Arbitration and lock logic stay in the top.

Test Plan:
- Reset, then r0 writes addr 0x005 = 0x1234 and r1 writes addr 0x3FF = 0xBEEF in the same cycle (PRIO_MODE=0) -> r0_gnt first cycle, r1_gnt next; mem_we pulses twice with the correct addr/din.
- r1 reads 0x3FF one cycle after the write -> r1_rvalid exactly 1 cycle after r1_gnt with r1_rdata=0xBEEF; r0_rvalid stays 0.
- Both request continuously for 8 cycles, RR mode -> grants alternate 0,1,0,1…. With PRIO_MODE=1 -> r0 gets all 8 grants and r1 gets none.
- r1 locks, reads 0x010, writes 0x010 = 0x0011 with lock=0, while r0 requests the whole time -> r0 gnt is blocked for exactly those 2 cycles and granted the next cycle.
- r1 holds lock=1 with continuous requests -> forced release after LOCK_MAX=15 locked cycles; r0 is granted on the following cycle.
- Assert rst_n low the cycle after a read grant -> no rvalid appears, all outputs return to 0. With MEM_ARB_OUTREG_EN defined, rerun the second scenario -> rvalid arrives 2 cycles after gnt.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// =============================================================================
// Module      : mem_arb_pkg
// Description : Shared constants and types for the program/data RAM port arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_LDST  = 1'b1;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_entry_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_rdpipe.sv
// =============================================================================
// Module      : mem_arb_rdpipe
// Description : {valid, id} read-return pipe that steers RAM dout to the reader.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_arb_rdpipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  rd_entry_t         push,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_rvalid
);

    rd_entry_t         r_stage [DEPTH];
    rd_entry_t         w_ret;
    logic [DATA_W-1:0] r_hold0;
    logic [DATA_W-1:0] r_hold1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign w_ret     = r_stage[DEPTH-1];
    assign r0_rvalid = w_ret.valid && (w_ret.id == REQ_FETCH);
    assign r1_rvalid = w_ret.valid && (w_ret.id == REQ_LDST);

    // RAM dout is live only during the return cycle; afterwards the hold copy is shown.
    assign r0_rdata = r0_rvalid ? mem_dout : r_hold0;
    assign r1_rdata = r1_rvalid ? mem_dout : r_hold1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold0 <= '0;
            r_hold1 <= '0;
        end else begin
            if (r0_rvalid) r_hold0 <= mem_dout;
            if (r1_rvalid) r_hold1 <= mem_dout;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// =============================================================================
// Module      : mem_port_arbiter
// Description : Two-requester arbiter (fetch / load-store) for one RAM port with
//               lockable read-modify-write. MEM_ARB_OUTREG_EN selects 2-cycle reads.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int PRIO_MODE = 0,
    parameter int LOCK_MAX  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

`ifdef MEM_ARB_OUTREG_EN
    localparam int RD_DEPTH = 2;
`else
    localparam int RD_DEPTH = 1;
`endif

    localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

    // COOLDOWN is unlocked for arbitration but masks the previous owner's lock input.
    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_LOCKED   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_lock_id;
    logic              w_lock_id_nxt;
    logic [3:0]        r_lock_cnt;
    logic [3:0]        w_lock_cnt_nxt;
    logic [3:0]        w_cnt_inc;
    logic              r_last_id;

    logic              w_lock_valid;
    logic              w_lock_block;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_win_valid;
    logic              w_win_id;
    logic              w_gnt_any;
    logic              w_win_we;
    logic              w_win_lock;
    logic              w_eff_lock;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic              w_owner_req;
    logic              w_owner_lock;
    rd_entry_t         w_push;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_UNLOCKED;
            r_lock_id  <= REQ_FETCH;
            r_lock_cnt <= '0;
            r_last_id  <= REQ_LDST;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_id  <= w_lock_id_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            if (w_gnt_any) r_last_id <= w_win_id;
        end
    end

    // FSM outputs
    always_comb begin
        w_lock_valid = (r_state == ST_LOCKED);
        w_lock_block = (r_state == ST_COOLDOWN);
    end

    assign w_elig0 = r0_req && (!w_lock_valid || (r_lock_id == REQ_FETCH));
    assign w_elig1 = r1_req && (!w_lock_valid || (r_lock_id == REQ_LDST));

    always_comb begin
        w_win_valid = w_elig0 || w_elig1;
        if (w_elig0 && w_elig1) begin
            w_win_id = (PRIO_MODE == PRIO_FIXED) ? REQ_FETCH : ~r_last_id;
        end else begin
            w_win_id = w_elig1 ? REQ_LDST : REQ_FETCH;
        end
    end

    always_comb begin
        w_win_we    = (w_win_id == REQ_LDST) ? r1_we    : r0_we;
        w_win_lock  = (w_win_id == REQ_LDST) ? r1_lock  : r0_lock;
        w_win_addr  = (w_win_id == REQ_LDST) ? r1_addr  : r0_addr;
        w_win_wdata = (w_win_id == REQ_LDST) ? r1_wdata : r0_wdata;
    end

    assign w_gnt_any  = w_win_valid && rst_n;
    assign r0_gnt     = w_gnt_any && (w_win_id == REQ_FETCH);
    assign r1_gnt     = w_gnt_any && (w_win_id == REQ_LDST);
    assign mem_we     = w_gnt_any && w_win_we;
    assign mem_addr   = w_gnt_any ? w_win_addr  : '0;
    assign mem_din    = w_gnt_any ? w_win_wdata : '0;

    assign w_eff_lock   = w_win_lock && !(w_lock_block && (r_lock_id == w_win_id));
    assign w_owner_req  = (r_lock_id == REQ_LDST) ? r1_req  : r0_req;
    assign w_owner_lock = (r_lock_id == REQ_LDST) ? r1_lock : r0_lock;
    assign w_cnt_inc    = (r_lock_cnt == LOCK_MAX_C) ? r_lock_cnt : r_lock_cnt + 4'd1;

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_id_nxt  = r_lock_id;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            ST_LOCKED: begin
                if (!w_owner_req || !w_owner_lock) begin
                    w_state_nxt    = ST_UNLOCKED;
                    w_lock_cnt_nxt = '0;
                end else if (w_cnt_inc == LOCK_MAX_C) begin
                    w_state_nxt    = ST_COOLDOWN;
                    w_lock_cnt_nxt = w_cnt_inc;
                end else begin
                    w_lock_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                if (w_gnt_any && w_eff_lock) begin
                    w_state_nxt    = ST_LOCKED;
                    w_lock_id_nxt  = w_win_id;
                    w_lock_cnt_nxt = '0;
                end else begin
                    w_state_nxt    = ST_UNLOCKED;
                end
            end
        endcase
    end

    always_comb begin
        w_push       = '0;
        w_push.valid = w_gnt_any && !w_win_we;
        w_push.id    = w_win_id;
    end

    mem_arb_rdpipe #(
        .DEPTH  (RD_DEPTH),
        .DATA_W (DATA_W)
    ) u_rdpipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .mem_dout  (mem_dout),
        .r0_rdata  (r0_rdata),
        .r0_rvalid (r0_rvalid),
        .r1_rdata  (r1_rdata),
        .r1_rvalid (r1_rvalid)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// =============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter (round-robin and fixed).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mem_port_arbiter;

`ifdef MEM_ARB_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int   LOCK_MAX = 15;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk;
    logic        rst_n;
    logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
    logic [9:0]  r0_addr, r1_addr;
    logic [15:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we;
    logic [15:0] r0_rdata, r1_rdata, mem_din, mem_dout;
    logic [9:0]  mem_addr;
    logic        fx_r0_gnt, fx_r1_gnt, fx_r0_rvalid, fx_r1_rvalid, fx_mem_we;
    logic [15:0] fx_r0_rdata, fx_r1_rdata, fx_mem_din;
    logic [9:0]  fx_mem_addr;
    logic [15:0] fx_dout;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(16), .PRIO_MODE(0), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(16), .PRIO_MODE(1), .LOCK_MAX(LOCK_MAX)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(fx_r0_gnt), .r0_rdata(fx_r0_rdata), .r0_rvalid(fx_r0_rvalid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(fx_r1_gnt), .r1_rdata(fx_r1_rdata), .r1_rvalid(fx_r1_rvalid),
        .mem_we(fx_mem_we), .mem_addr(fx_mem_addr), .mem_din(fx_mem_din), .mem_dout(fx_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign fx_dout = 16'h0000;

    function automatic logic [15:0] pat(input int i);
        return 16'((i * 16'h0123) ^ 16'h5A5A);
    endfunction

    // Synchronous-read RAM, optionally with the output register stage.
    logic [15:0] ram [0:1023];
    logic [15:0] ram_q, ram_q2;
    logic        ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_din;
        end
        ram_q  <= ram[mem_addr];
        ram_q2 <= ram_q;
    end
    assign mem_dout = (LAT == 2) ? ram_q2 : ram_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic q0, input logic w0, input logic l0, input logic [9:0] a0,
                         input logic [15:0] d0, input logic q1, input logic w1, input logic l1,
                         input logic [9:0] a1, input logic [15:0] d1);
        r0_req = q0; r0_we = w0; r0_lock = l0; r0_addr = a0; r0_wdata = d0;
        r1_req = q1; r1_we = w1; r1_lock = l1; r1_addr = a1; r1_wdata = d1;
    endtask

    task automatic idle();
        drive(F, F, F, 10'h0, 16'h0, F, F, F, 10'h0, 16'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " gnt0"}, r0_gnt, 0);
        chk({tag, " gnt1"}, r1_gnt, 0);
        chk({tag, " mem_we"}, mem_we, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_din"}, mem_din, 0);
        chk({tag, " rvalid0"}, r0_rvalid, 0);
        chk({tag, " rvalid1"}, r1_rvalid, 0);
        chk({tag, " rdata0"}, r0_rdata, 0);
        chk({tag, " rdata1"}, r1_rdata, 0);
    endtask

    typedef struct {
        logic q0, w0, l0; logic [9:0] a0; logic [15:0] d0;
        logic q1, w1, l1; logic [9:0] a1; logic [15:0] d1;
        logic eg0, eg1, ewe; logic [9:0] eaddr; logic [15:0] edin;
        logic fg0, fg1;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    // Reference model state for the randomized phase.
    typedef struct { int id; logic [15:0] data; int due; } ret_t;
    ret_t        pend [$];
    logic [15:0] mmem [1024];
    logic [15:0] m_hold [2];
    int  m_last, m_owner, m_nlocked, m_cool_id;
    bit  m_locked, m_cool;

    initial begin
        // Contended writes, then 8 contended reads, then a locked read-modify-write.
        tbl[0]  = '{T,T,F,10'h005,16'h1234, T,T,F,10'h3FF,16'hBEEF, T,F,T,10'h005,16'h1234, T,F};
        tbl[1]  = '{F,F,F,10'h000,16'h0000, T,T,F,10'h3FF,16'hBEEF, F,T,T,10'h3FF,16'hBEEF, F,T};
        for (int k = 0; k < 8; k++) begin
            tbl[2+k] = '{T,F,F,10'h001,16'h0000, T,F,F,10'h002,16'h0000,
                         (k % 2 == 0), (k % 2 == 1), F, (k % 2 == 0) ? 10'h001 : 10'h002,
                         16'h0000, T, F};
        end
        tbl[10] = '{T,F,F,10'h001,16'h0000, F,F,F,10'h000,16'h0000, T,F,F,10'h001,16'h0000, T,F};
        tbl[11] = '{T,F,F,10'h020,16'h0000, T,F,T,10'h010,16'h0000, F,T,F,10'h010,16'h0000, T,F};
        tbl[12] = '{T,F,F,10'h020,16'h0000, T,T,F,10'h010,16'h0011, F,T,T,10'h010,16'h0011, T,F};
        tbl[13] = '{T,F,F,10'h020,16'h0000, F,F,F,10'h000,16'h0000, T,F,F,10'h020,16'h0000, T,F};
        tbl[14] = '{F,F,F,10'h000,16'h0000, F,F,F,10'h000,16'h0000, F,F,F,10'h000,16'h0000, F,F};

        // Reset with requests asserted: everything must stay quiet.
        rst_n    = 1'b0;
        ram_init = 1'b1;
        drive(T, T, T, 10'h155, 16'hAAAA, T, T, T, 10'h2AA, 16'h5555);
        next_cycle();
        ram_init = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].q0, tbl[i].w0, tbl[i].l0, tbl[i].a0, tbl[i].d0,
                  tbl[i].q1, tbl[i].w1, tbl[i].l1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("tbl%0d gnt0", i), r0_gnt, tbl[i].eg0);
            chk($sformatf("tbl%0d gnt1", i), r1_gnt, tbl[i].eg1);
            chk($sformatf("tbl%0d mem_we", i), mem_we, tbl[i].ewe);
            chk($sformatf("tbl%0d mem_addr", i), mem_addr, tbl[i].eaddr);
            chk($sformatf("tbl%0d mem_din", i), mem_din, tbl[i].edin);
            chk($sformatf("tbl%0d fx_gnt0", i), fx_r0_gnt, tbl[i].fg0);
            chk($sformatf("tbl%0d fx_gnt1", i), fx_r1_gnt, tbl[i].fg1);
            next_cycle();
        end
        idle();
        next_cycle();

        // Read-back of 0x3FF by requester 1 with exact latency and hold.
        drive(F, F, F, 10'h0, 16'h0, T, F, F, 10'h3FF, 16'h0);
        @(negedge clk);
        chk("rd gnt1", r1_gnt, 1);
        chk("rd rvalid1 at gnt", r1_rvalid, 0);
        next_cycle();
        idle();
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            chk($sformatf("rd rvalid1 +%0d", k), r1_rvalid, (k == LAT));
            chk($sformatf("rd rvalid0 +%0d", k), r0_rvalid, 0);
            if (k >= LAT) chk($sformatf("rd rdata1 +%0d", k), r1_rdata, 16'hBEEF);
            next_cycle();
        end

        // Forced lock release: 1 locking grant + 15 locked cycles, then r0.
        drive(T, F, F, 10'h030, 16'h0, F, F, F, 10'h0, 16'h0);
        @(negedge clk);
        chk("frc pre gnt0", r0_gnt, 1);
        next_cycle();
        drive(T, F, F, 10'h030, 16'h0, T, F, T, 10'h031, 16'h0);
        for (int k = 0; k < LOCK_MAX + 2; k++) begin
            @(negedge clk);
            chk($sformatf("frc gnt1 c%0d", k), r1_gnt, (k <= LOCK_MAX));
            chk($sformatf("frc gnt0 c%0d", k), r0_gnt, (k == LOCK_MAX + 1));
            next_cycle();
        end
        idle();
        repeat (LAT + 1) next_cycle();

        // Reset asserted the cycle after a read grant drops the pending return.
        drive(F, F, F, 10'h0, 16'h0, T, F, F, 10'h3FF, 16'h0);
        @(negedge clk);
        chk("rstrd gnt1", r1_gnt, 1);
        next_cycle();
        drive(T, T, T, 10'h111, 16'h2222, T, T, T, 10'h333, 16'h4444);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstrd async");
        @(negedge clk);
        chk_all_zero("rstrd held");
        next_cycle();
        idle();
        rst_n = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            chk($sformatf("rstrd rvalid1 +%0d", k), r1_rvalid, 0);
            chk($sformatf("rstrd rdata1 +%0d", k), r1_rdata, 0);
            next_cycle();
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1024; i++) mmem[i] = pat(i);
        m_hold[0] = 16'h0; m_hold[1] = 16'h0;
        m_last = 1; m_locked = 0; m_cool = 0; m_owner = 0; m_nlocked = 0; m_cool_id = 0;
        pend.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit          rq [2];
            bit          wq [2];
            bit          lk [2];
            logic [9:0]  ad [2];
            logic [15:0] wd [2];
            bit          e0, e1, cool_now, ev [2];
            int          w, ph;
            ph = (cyc / 100) % 3;
            for (int j = 0; j < 2; j++) begin
                rq[j] = ($urandom_range(0, 3) != 0);
                wq[j] = ($urandom_range(0, 2) == 0);
                lk[j] = ($urandom_range(0, 3) == 0);
                ad[j] = 10'(10'h100 + $urandom_range(0, 63));
                wd[j] = 16'($urandom);
            end
            if (ph == 1) begin rq[0] = 1; lk[0] = 1; end
            if (ph == 2) begin rq[1] = 1; lk[1] = 1; end
            drive(rq[0], wq[0], lk[0], ad[0], wd[0], rq[1], wq[1], lk[1], ad[1], wd[1]);

            e0 = rq[0] && (!m_locked || m_owner == 0);
            e1 = rq[1] && (!m_locked || m_owner == 1);
            if (e0 && e1)  w = (m_last == 0) ? 1 : 0;
            else if (e0)   w = 0;
            else if (e1)   w = 1;
            else           w = -1;
            ev[0] = 0; ev[1] = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                ev[pend[0].id]     = 1;
                m_hold[pend[0].id] = pend[0].data;
                void'(pend.pop_front());
            end

            @(negedge clk);
            chk("rnd gnt0", r0_gnt, (w == 0));
            chk("rnd gnt1", r1_gnt, (w == 1));
            chk("rnd mem_we", mem_we, (w >= 0) ? wq[w] : 1'b0);
            chk("rnd mem_addr", mem_addr, (w >= 0) ? ad[w] : 10'h0);
            chk("rnd mem_din", mem_din, (w >= 0) ? wd[w] : 16'h0);
            chk("rnd rvalid0", r0_rvalid, ev[0]);
            chk("rnd rvalid1", r1_rvalid, ev[1]);
            chk("rnd rdata0", r0_rdata, m_hold[0]);
            chk("rnd rdata1", r1_rdata, m_hold[1]);

            if (w >= 0) begin
                if (wq[w]) mmem[ad[w]] = wd[w];
                else       pend.push_back('{w, mmem[ad[w]], cyc + LAT});
                m_last = w;
            end
            cool_now = m_cool;
            m_cool   = 0;
            if (m_locked) begin
                if (!rq[m_owner] || !lk[m_owner]) begin
                    m_locked = 0;
                end else begin
                    m_nlocked++;
                    if (m_nlocked == LOCK_MAX) begin
                        m_locked = 0; m_cool = 1; m_cool_id = m_owner;
                    end
                end
            end else if (w >= 0 && lk[w] && !(cool_now && m_cool_id == w)) begin
                m_locked = 1; m_owner = w; m_nlocked = 0;
            end
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
